// File: rtl/timer_sched.sv
// timer_sched: shared prescaler driving NCH one-shot/periodic timer channels,
// with round-robin arbitration of expiry events onto one valid/ready port.
module timer_sched #(
    parameter int unsigned PRESC = 8,
    parameter int unsigned NCH   = 4,
    parameter int unsigned CW    = 8,
    parameter int unsigned CHW   = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_period,
    input  logic           cfg_mode,
    input  logic           cfg_start,
    output logic           ptick,
    output logic           evt_valid,
    output logic [CHW-1:0] evt_ch,
    input  logic           evt_ready,
    output logic [NCH-1:0] busy,
    output logic [NCH-1:0] ovf
);

    localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

    if (PRESC < 2) begin : g_bad_presc
        $error("timer_sched: PRESC must be >= 2");
    end
    if (NCH < 2) begin : g_bad_nch
        $error("timer_sched: NCH must be >= 2");
    end

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } arb_state_e;

    logic [PW-1:0]  pcnt_q, pcnt_d;
    logic           ptick_q, ptick_d;

    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];
    logic [CW-1:0]  rld_q [NCH];
    logic [CW-1:0]  rld_d [NCH];
    logic [NCH-1:0] mode_q, mode_d;
    logic [NCH-1:0] busy_q, busy_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] ovf_q, ovf_d;

    arb_state_e     state_q, state_d;
    logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
    logic           evt_valid_q, evt_valid_d;
    logic [CHW-1:0] evt_ch_q, evt_ch_d;

    logic           wr_ok_c;
    logic           hs_c;
    logic [NCH-1:0] acc_c;
    logic           sel_found_c;
    logic [CHW-1:0] sel_ch_c;
    logic [CHW-1:0] idx_c;

    assign wr_ok_c = cfg_we && (32'(cfg_ch) < NCH);
    assign hs_c    = (state_q == S_OFFER) && evt_ready;

    // Prescaler: modulo-PRESC count on enabled cycles, one-cycle tick on wrap
    always_comb begin
        pcnt_d  = pcnt_q;
        ptick_d = 1'b0;
        if (en) begin
            if (pcnt_q == PW'(PRESC - 1)) begin
                pcnt_d  = '0;
                ptick_d = 1'b1;
            end else begin
                pcnt_d = pcnt_q + PW'(1);
            end
        end
    end

    // Per-channel handshake acceptance decode
    always_comb begin
        acc_c = '0;
        for (int i = 0; i < NCH; i++) begin
            acc_c[i] = hs_c && (evt_ch_q == CHW'(i));
        end
    end

    // Channel counters: config write wins over the tick for the addressed channel
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            rld_d[i] = rld_q[i];
        end
        mode_d = mode_q;
        busy_d = busy_q;
        pend_d = pend_q & ~acc_c;
        ovf_d  = ovf_q;
        for (int i = 0; i < NCH; i++) begin
            if (wr_ok_c && (cfg_ch == CHW'(i))) begin
                busy_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
                if (cfg_start && (cfg_period != '0)) begin
                    cnt_d[i]  = cfg_period - CW'(1);
                    rld_d[i]  = cfg_period - CW'(1);
                    mode_d[i] = cfg_mode;
                    busy_d[i] = 1'b1;
                end
            end else if (ptick_q && busy_q[i]) begin
                if (cnt_q[i] != '0) begin
                    cnt_d[i] = cnt_q[i] - CW'(1);
                end else begin
                    if (pend_q[i] && !acc_c[i]) begin
                        ovf_d[i] = 1'b1;
                    end
                    pend_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = rld_q[i];
                    end else begin
                        busy_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Arbiter: pick first pending channel at or after rr_ptr, hold offer until accepted
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        sel_found_c = 1'b0;
        sel_ch_c    = '0;
        idx_c       = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_c = CHW'((32'(rr_ptr_q) + 32'(k)) % NCH);
            if (!sel_found_c && pend_q[idx_c]) begin
                sel_found_c = 1'b1;
                sel_ch_c    = idx_c;
            end
        end
        case (state_q)
            S_IDLE: begin
                if (sel_found_c) begin
                    evt_ch_d    = sel_ch_c;
                    evt_valid_d = 1'b1;
                    state_d     = S_OFFER;
                end
            end
            S_OFFER: begin
                if (evt_ready) begin
                    evt_valid_d = 1'b0;
                    rr_ptr_d    = (evt_ch_q == CHW'(NCH - 1)) ? '0 : evt_ch_q + CHW'(1);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                evt_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q      <= '0;
            ptick_q     <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
                rld_q[i] <= '0;
            end
            mode_q      <= '0;
            busy_q      <= '0;
            pend_q      <= '0;
            ovf_q       <= '0;
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
        end else begin
            pcnt_q      <= pcnt_d;
            ptick_q     <= ptick_d;
            cnt_q       <= cnt_d;
            rld_q       <= rld_d;
            mode_q      <= mode_d;
            busy_q      <= busy_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
        end
    end

    assign ptick     = ptick_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched (PRESC=4, NCH=4, CW=8).
module tb_timer_sched;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 8;
    localparam int unsigned CHW = 2;

    logic           clk;
    logic           rst;
    logic           en;
    logic           cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_period;
    logic           cfg_mode;
    logic           cfg_start;
    logic           ptick;
    logic           evt_valid;
    logic [CHW-1:0] evt_ch;
    logic           evt_ready;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] ovf;

    int n_tests;
    int n_fail;

    timer_sched #(.PRESC(4), .NCH(NCH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_mode   (cfg_mode),
        .cfg_start  (cfg_start),
        .ptick      (ptick),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .busy       (busy),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Negedges until ptick is seen (bounded)
    task automatic wait_ptick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ptick && n < 200);
    endtask

    // Negedges until evt_valid is seen (bounded)
    task automatic wait_evt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt_valid && n < 200);
    endtask

    // One-cycle config write, returns at the following negedge
    task automatic cfg_write(input int ch, input int period, input bit mode, input bit start);
        cfg_we     = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = CW'(period);
        cfg_mode   = mode;
        cfg_start  = start;
        @(negedge clk);
        cfg_we     = 1'b0;
        cfg_start  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int cnt_ev;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_period = '0;
        cfg_mode = 1'b0; cfg_start = 1'b0; evt_ready = 1'b0;
        step(2);
        check("rst_ptick", 32'(ptick), 0);
        check("rst_evt_valid", 32'(evt_valid), 0);
        check("rst_evt_ch", 32'(evt_ch), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(ovf), 0);

        // 1. Prescaler
        rst = 1'b0; en = 1'b1;
        wait_ptick(n);  check("t1_first_ptick", n, 4);
        step(1);        check("t1_ptick_width", 32'(ptick), 0);
        wait_ptick(n);  check("t1_spacing_a", n + 1, 4);
        wait_ptick(n);  check("t1_spacing_b", n, 4);
        en = 1'b0;
        step(3);        check("t1_hold_ptick", 32'(ptick), 0);
        en = 1'b1;
        wait_ptick(n);  check("t1_stretch", n + 3, 7);

        // 2. Periodic ch0, period 3, always ready
        evt_ready = 1'b1;
        wait_ptick(n);
        cfg_write(0, 3, 1'b1, 1'b1);
        wait_evt(n);    check("t2_first_lat", n, 13);
        check("t2_ch_first", 32'(evt_ch), 0);
        for (int r = 0; r < 2; r++) begin
            wait_evt(n);
            check("t2_period", n, 12);
            check("t2_ch", 32'(evt_ch), 0);
            check("t2_busy0", 32'(busy[0]), 1);
        end
        cfg_write(0, 0, 1'b0, 1'b0);
        step(10);
        check("t2_stop_busy", 32'(busy), 0);
        check("t2_stop_evt", 32'(evt_valid), 0);

        // 4. Round robin ch1/ch3 with rr_ptr=1
        wait_ptick(n);
        cfg_write(1, 2, 1'b1, 1'b1);
        cfg_write(3, 2, 1'b1, 1'b1);
        wait_evt(n); check("t4_r1_lat", n, 8); check("t4_r1_a", 32'(evt_ch), 1);
        wait_evt(n); check("t4_r1_gap", n, 2); check("t4_r1_b", 32'(evt_ch), 3);
        wait_evt(n); check("t4_r2_lat", n, 6); check("t4_r2_a", 32'(evt_ch), 1);
        wait_evt(n); check("t4_r2_gap", n, 2); check("t4_r2_b", 32'(evt_ch), 3);
        cfg_write(1, 0, 1'b0, 1'b0);
        cfg_write(3, 0, 1'b0, 1'b0);
        step(10);
        check("t4_stop_evt", 32'(evt_valid), 0);
        check("t4_stop_busy", 32'(busy), 0);

        // One-shot event on ch1 leaves rr_ptr=2
        wait_ptick(n);
        cfg_write(1, 1, 1'b0, 1'b1);
        wait_evt(n); check("t4_os_lat", n, 5); check("t4_os_ch", 32'(evt_ch), 1);

        // Re-arm ch1/ch3: ch3 now served first
        wait_ptick(n);
        cfg_write(1, 2, 1'b1, 1'b1);
        cfg_write(3, 2, 1'b1, 1'b1);
        wait_evt(n); check("t4b_r1_lat", n, 8); check("t4b_r1_a", 32'(evt_ch), 3);
        wait_evt(n); check("t4b_r1_gap", n, 2); check("t4b_r1_b", 32'(evt_ch), 1);
        wait_evt(n); check("t4b_r2_lat", n, 6); check("t4b_r2_a", 32'(evt_ch), 3);
        wait_evt(n); check("t4b_r2_gap", n, 2); check("t4b_r2_b", 32'(evt_ch), 1);
        cfg_write(1, 0, 1'b0, 1'b0);
        cfg_write(3, 0, 1'b0, 1'b0);
        step(10);
        check("t4b_stop_evt", 32'(evt_valid), 0);
        check("t4b_stop_busy", 32'(busy), 0);

        // 3. One-shot ch2, period 1
        wait_ptick(n);
        cfg_write(2, 1, 1'b0, 1'b1);
        step(3);
        check("t3_tick", 32'(ptick), 1);
        check("t3_busy_before", 32'(busy[2]), 1);
        step(1);
        check("t3_busy_after", 32'(busy[2]), 0);
        wait_evt(n); check("t3_lat", n, 1); check("t3_ch", 32'(evt_ch), 2);
        cnt_ev = 0;
        for (int c = 0; c < 50; c++) begin
            step(1);
            if (evt_valid) cnt_ev++;
        end
        check("t3_no_more", cnt_ev, 0);

        // 5. Backpressure and overflow on ch0, period 1
        evt_ready = 1'b0;
        wait_ptick(n);                                   // X
        cfg_write(0, 1, 1'b1, 1'b1);                     // X+1
        step(4);  check("t5_not_yet", 32'(evt_valid), 0);  // X+5
        step(1);  check("t5_valid", 32'(evt_valid), 1);    // X+6
        check("t5_ch", 32'(evt_ch), 0);
        step(2);  check("t5_tick2", 32'(ptick), 1);        // X+8
        check("t5_ovf_pre", 32'(ovf), 0);
        check("t5_held_valid", 32'(evt_valid), 1);
        step(1);  check("t5_ovf_set", 32'(ovf), 1);        // X+9
        check("t5_held_ch", 32'(evt_ch), 0);
        step(1);  evt_ready = 1'b1;                       // X+10
        step(1);  evt_ready = 1'b0;                       // X+11
        check("t5_hs_drop", 32'(evt_valid), 0);
        check("t5_ovf_sticky", 32'(ovf), 1);
        step(3);  check("t5_new_evt", 32'(evt_valid), 1);  // X+14
        check("t5_ovf_sticky2", 32'(ovf), 1);
        cfg_write(0, 1, 1'b1, 1'b1);                     // X+15
        check("t5_ovf_clr", 32'(ovf), 0);
        check("t5_pend_kept", 32'(evt_valid), 1);
        step(1);  check("t5_tick4", 32'(ptick), 1);        // X+16
        evt_ready = 1'b1;
        step(1);  evt_ready = 1'b0;                       // X+17
        check("t5_same_cyc_drop", 32'(evt_valid), 0);
        check("t5_same_cyc_ovf", 32'(ovf), 0);
        step(1);  check("t5_same_cyc_repend", 32'(evt_valid), 1);  // X+18
        check("t5_same_cyc_ch", 32'(evt_ch), 0);

        // 6. Reset mid-operation
        cfg_write(1, 5, 1'b1, 1'b1);                     // X+19
        check("t6_busy_two", 32'(busy), 3);
        step(2);  check("t6_ovf_pre", 32'(ovf), 1);        // X+21
        #1 rst = 1'b1;
        #1;
        check("t6_rst_ptick", 32'(ptick), 0);
        check("t6_rst_valid", 32'(evt_valid), 0);
        check("t6_rst_ch", 32'(evt_ch), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_ovf", 32'(ovf), 0);
        step(2);
        rst = 1'b0;
        wait_ptick(n);  check("t6_first_ptick", n, 4);
        cnt_ev = 0;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (evt_valid) cnt_ev++;
        end
        check("t6_quiet", cnt_ev, 0);
        check("t6_quiet_busy", 32'(busy), 0);
        evt_ready = 1'b1;
        cfg_write(1, 1, 1'b0, 1'b1);
        wait_evt(n);
        check("t6_rearm_seen", 32'(n <= 8), 1);
        check("t6_rearm_ch", 32'(evt_ch), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_sched.md
# timer_sched

Multi-channel timer scheduler. It owns one shared prescaler, a modulo-PRESC counter that produces a tick every PRESC enabled cycles, and sequences NCH software timer channels off that tick. Each channel runs in one-shot or periodic mode. Expiry events are arbitrated round-robin onto a single valid/ready event port. It sits between the control/config logic and any consumer that needs periodic or delayed strobes, and replaces per-consumer free-running counters.

## Interface
Parameters:
- PRESC, 8: prescaler modulus; must be ≥2, elaboration error otherwise.
- NCH, 4: number of timer channels; must be ≥2.
- CW, 8: channel period/counter width.
- CHW, $clog2(NCH): channel index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  global enable; gates the prescaler.
- cfg_we  in  1  config write strobe, single cycle.
- cfg_ch  in  CHW  channel addressed by cfg_we.
- cfg_period  in  CW  period in prescaler ticks.
- cfg_mode  in  1  0 = one-shot, 1 = periodic.
- cfg_start  in  1  1 = arm channel, 0 = stop channel.
- ptick  out  1  registered prescaler tick pulse.
- evt_valid  out  1  expiry event offered.
- evt_ch  out  CHW  channel of the offered event.
- evt_ready  in  1  consumer accepts the event.
- busy  out  NCH  per-channel running flag.
- ovf  out  NCH  per-channel sticky lost-event flag.

## Operation
Prescaler:
- pcnt counts 0..PRESC-1 on cycles with en=1 and holds when en=0.
- On an en=1 cycle with pcnt==PRESC-1: pcnt wraps to 0 and ptick is registered to 1.
- On every other cycle ptick is registered to 0, including all cycles with en=0.

Config write (cfg_we=1):
- cfg_start=1 and cfg_period≠0: cnt[ch]=cfg_period-1, mode[ch]=cfg_mode, busy[ch]=1, ovf[ch]=0.
- cfg_start=1 and cfg_period=0: busy[ch]=0, ovf[ch]=0. The channel is not armed.
- cfg_start=0: busy[ch]=0, ovf[ch]=0.
- A stop does not cancel a pending event.
- Writing to a running channel reloads it immediately.

Channel update, on ptick=1 for each channel with busy=1 that is not written this cycle:
- cnt≠0: cnt decrements by 1.
- cnt==0: the channel expires.
  - pend is set.
  - Periodic: cnt reloads to period-1.
  - One-shot: busy clears.
- Expiry while pend is already set and not being accepted this cycle: ovf is set, and pend stays at 1.
- Result: P ticks between expiries for period P.

Arbiter, two states:
- IDLE:
  - If any pend bit is set, select the first pending channel at or after rr_ptr, cyclically.
  - Register evt_ch and evt_valid=1, then go to OFFER.
- OFFER:
  - evt_valid and evt_ch are held stable until evt_ready=1.
  - On handshake: clear pend[evt_ch], set rr_ptr=evt_ch+1 (mod NCH), set evt_valid=0, go to IDLE.

Boundary rules:
- Expiry and handshake on the same channel in the same cycle: pend ends at 1 (new event) and ovf is not set.
- cfg_we and ptick in the same cycle: the config write wins for the addressed channel. Other channels update normally.
- cfg_ch ≥ NCH: the write is ignored.
- rst at any time: pcnt, cnt, busy, pend, ovf, rr_ptr, ptick, evt_valid and evt_ch all go to 0 immediately, and the arbiter goes to IDLE.

## Timing
- Reset value of every output is 0.
- First ptick: the cycle after the PRESC-th enabled edge following reset release.
- Expiry latency:
  - The ptick cycle updates cnt and pend at the end of that cycle.
  - pend is visible the next cycle.
  - evt_valid rises the cycle after that, i.e. 2 cycles after ptick.
- Throughput: at most one event per 2 cycles. evt_valid is always low for the cycle after a handshake.
- Arming: a config write at edge t makes busy high from t+1. With period P, the first expiry ptick is the P-th ptick after t.
- evt_valid never drops without a handshake, except by reset.

## Test plan
Bench configuration: PRESC=4, NCH=4, CW=8.
1. Prescaler:
   - Release rst, en=1 → ptick pulses exactly every 4 cycles, one cycle wide.
   - en=0 for 3 cycles → ptick spacing stretches to 7 cycles.
2. Periodic channel:
   - ch0 periodic, period 3, evt_ready tied to 1 → evt_valid with evt_ch=0 every 12 cycles, each 2 cycles after the ptick.
   - busy[0] stays 1.
3. One-shot channel:
   - ch2 one-shot, period 1 → exactly one event with evt_ch=2.
   - busy[2] falls the cycle after the expiring ptick.
   - No further events for 50 cycles.
4. Round-robin ordering:
   - ch1 and ch3 both periodic, period 2, armed in the same cycle via two writes, ready=1 → events alternate ch1, ch3 in the same order every round.
   - Re-arm with rr_ptr=2 → ch3 is served before ch1.
5. Backpressure and overflow:
   - ch0 periodic, period 1, evt_ready=0 → evt_ch=0 is held stable.
   - ovf[0]=1 after the second ptick.
   - Raising ready → a single handshake, and ovf[0] stays 1 until a cfg write to ch0.
6. Reset mid-operation:
   - Assert rst while evt_valid=1 and two channels are busy → all outputs 0 asynchronously.
   - After release, no event appears until a channel is re-armed.
